// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the value source, the bin2bcd_seq converter and the 7-seg multiplexer.
// Latency: none (wires only).
// Backpressure: none; start_i is only honoured while the converter is idle.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start_i;
    logic [WIDTH-1:0]      bin_i;
    logic                  busy_o;
    logic                  done_o;
    logic [4*DIGITS-1:0]   bcd_o;
    logic [DIGITS-1:0]     blank_o;
    logic                  overflow_o;
    logic                  sign_o;

    modport master (
        output start_i, bin_i,
        input  busy_o, done_o, bcd_o, blank_o, overflow_o, sign_o
    );

    modport slave (
        input  start_i, bin_i,
        output busy_o, done_o, bcd_o, blank_o, overflow_o, sign_o
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per enabled clock) with saturation and blank mask.
// Latency: start accepted on edge N -> done_o high after edge N+WIDTH+1; en=0 stretches it cycle for cycle.
// Backpressure: start_i ignored while busy_o; optional two's-complement input via SIGNED_MODE_EN.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    bin2bcd_seq_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic              ovf_q, ovf_d;
    logic              neg_q, neg_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              ovfo_q, ovfo_d;
    logic              sign_q, sign_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  mag;
    logic              neg;
    logic [BW-1:0]     adj;
    logic [DIGITS-1:0] blank_nx;
    logic              allz;

`ifdef SIGNED_MODE_EN
    // Magnitude of the two's-complement input; the most negative value maps to 2^(WIDTH-1) without wrap.
    assign neg = bus.bin_i[WIDTH-1];
    assign mag = neg ? (~bus.bin_i + WIDTH'(1)) : bus.bin_i;
`else
    assign neg = 1'b0;
    assign mag = bus.bin_i;
`endif

    // Add-3 correction: every scratch nibble of 5 or more is bumped before the shift.
    always_comb begin
        adj = scr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero mask of the finished scratch: digit k blanks when it and all above are zero; units always lit.
    always_comb begin
        blank_nx = '0;
        allz     = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            allz = allz && (scr_q[4*k +: 4] == 4'd0);
            if (k > 0) begin
                blank_nx[k] = allz;
            end
        end
    end

    // Next-state logic; with en low everything holds and done drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        ovfo_d  = ovfo_q;
        sign_d  = sign_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        shift_d = mag;
                        scr_d   = '0;
                        ovf_d   = 1'b0;
                        neg_d   = neg;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // A 1 leaving the top nibble means the value no longer fits in DIGITS digits.
                    scr_d   = {adj[BW-2:0], shift_q[WIDTH-1]};
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    ovf_d   = ovf_q | adj[BW-1];
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    bcd_d   = ovf_q ? {DIGITS{4'h9}} : scr_q;
                    blank_d = ovf_q ? '0 : blank_nx;
                    ovfo_d  = ovf_q;
                    sign_d  = neg_q & (ovf_q | (|scr_q));
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and result registers; reset aborts any conversion and clears the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            scr_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            blank_q <= '0;
            ovfo_q  <= 1'b0;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            ovfo_q  <= ovfo_d;
            sign_q  <= sign_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.done_o     = done_q;
    assign bus.bcd_o      = bcd_q;
    assign bus.blank_o    = blank_q;
    assign bus.overflow_o = ovfo_q;
    assign bus.sign_o     = sign_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 5-digit and a 4-digit converter share stimulus and are compared every cycle
// against an arithmetic model (value -> decimal digits, saturation, blank mask, latency), plus literal checks.
module tb_bin2bcd_seq;
    typedef struct packed {
        logic [19:0] bcd;
        logic [4:0]  blank;
        logic        ovf;
        logic        sign;
    } res_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        en    = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin   = '0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) b5 ();
    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(4)) b4 ();

    assign b5.start_i = start;
    assign b5.bin_i   = bin;
    assign b4.start_i = start;
    assign b4.bin_i   = bin;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u5 (.clk(clk), .rst(rst), .en(en), .bus(b5.slave));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) u4 (.clk(clk), .rst(rst), .en(en), .bus(b4.slave));

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decimal result of a request, computed by plain arithmetic.
    function automatic res_t model(input logic [15:0] b, input int nd);
        res_t r;
        int   mag;
        int   v;
        int   lim;
        bit   neg;
        r   = '0;
        mag = int'(b);
        neg = 1'b0;
`ifdef SIGNED_MODE_EN
        neg = b[15];
        if (neg) mag = 65536 - mag;
`endif
        lim = 10 ** nd;
        if (mag >= lim) begin
            r.ovf = 1'b1;
            for (int k = 0; k < nd; k++) r.bcd[4*k +: 4] = 4'h9;
        end else begin
            v = mag;
            for (int k = 0; k < nd; k++) begin
                r.bcd[4*k +: 4] = 4'(v % 10);
                v = v / 10;
            end
            for (int k = 1; k < nd; k++) r.blank[k] = (mag < 10 ** k);
        end
        r.sign = neg && (mag != 0);
        return r;
    endfunction

    // Timing model: an accepted request completes WIDTH+1 enabled clocks later.
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;
    int   m_cnt  = 0;
    res_t m_pend [2];
    res_t m_exp  [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_cnt    = 0;
            m_exp[0] = '0;
            m_exp[1] = '0;
        end else begin
            m_done = 1'b0;
            if (en) begin
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy   = 1'b0;
                        m_done   = 1'b1;
                        m_exp[0] = m_pend[0];
                        m_exp[1] = m_pend[1];
                    end
                end else if (start) begin
                    m_busy    = 1'b1;
                    m_cnt     = 17;
                    m_pend[0] = model(bin, 5);
                    m_pend[1] = model(bin, 4);
                end
            end
        end
    end

    // Per-cycle comparison of both converters against the model.
    always begin
        @(negedge clk);
        #2;
        if (chk_on) begin
            chk("busy5",  b5.busy_o,     m_busy);
            chk("done5",  b5.done_o,     m_done);
            chk("bcd5",   b5.bcd_o,      m_exp[0].bcd);
            chk("blank5", b5.blank_o,    m_exp[0].blank);
            chk("ovf5",   b5.overflow_o, m_exp[0].ovf);
            chk("sign5",  b5.sign_o,     m_exp[0].sign);
            chk("busy4",  b4.busy_o,     m_busy);
            chk("done4",  b4.done_o,     m_done);
            chk("bcd4",   b4.bcd_o,      m_exp[1].bcd[15:0]);
            chk("blank4", b4.blank_o,    m_exp[1].blank[3:0]);
            chk("ovf4",   b4.overflow_o, m_exp[1].ovf);
            chk("sign4",  b4.sign_o,     m_exp[1].sign);
        end
    end

    // One request; lat counts negedges from the accepting edge until done_o is seen.
    task automatic convert(input logic [15:0] v, output int lat);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = 16'($urandom);
        chk("busy_after_start", b5.busy_o, 1);
        lat = 1;
        while (!b5.done_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", b5.done_o, 1);
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (b5.done_o) nd++;
        end
    endtask

    int          lat;
    int          nd;
    int          nd_rand;
    logic [15:0] rv;
    res_t        pr;

    initial begin
        #1 rst = 1'b1;
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",  b5.busy_o, 0);
        chk("rst_done",  b5.done_o, 0);
        chk("rst_bcd",   b5.bcd_o, 0);
        chk("rst_blank", b5.blank_o, 0);
        chk("rst_ovf",   b5.overflow_o, 0);
        chk("rst_sign",  b5.sign_o, 0);
        rst = 1'b0;
        en  = 1'b1;
        repeat (2) @(negedge clk);

        // Model pins.
        pr = model(16'd10000, 4);
        chk("pin_ovf4", {pr.ovf, pr.bcd[15:0]}, {1'b1, 16'h9999});
        pr = model(16'd305, 5);
        chk("pin_305", {pr.bcd, pr.blank}, {20'h00305, 5'b11000});

        // First request: latency and value.
        convert(16'd65233, lat);
        chk("latency", lat - 1, 17);
`ifndef SIGNED_MODE_EN
        chk("t1_bcd",   b5.bcd_o, 20'h65233);
        chk("t1_blank", b5.blank_o, 5'b00000);
        chk("t1_ovf",   b5.overflow_o, 0);
`endif

        convert(16'd0, lat);
        chk("zero_bcd",    b5.bcd_o, 20'h00000);
        chk("zero_blank",  b5.blank_o, 5'b11110);
        chk("zero_blank4", b4.blank_o, 4'b1110);
        convert(16'd42, lat);
        chk("d42_bcd",   b5.bcd_o, 20'h00042);
        chk("d42_blank", b5.blank_o, 5'b11100);

        convert(16'd12345, lat);
        chk("ovf4_flag", b4.overflow_o, 1);
        chk("ovf4_bcd",  b4.bcd_o, 16'h9999);
        chk("ovf4_blnk", b4.blank_o, 0);
        chk("d12345_5",  b5.bcd_o, 20'h12345);
        convert(16'd9999, lat);
        chk("d9999_ovf", b4.overflow_o, 0);
        chk("d9999_bcd", b4.bcd_o, 16'h9999);

        // Restart ignored while busy, then en low for 5 clocks mid-conversion.
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd65233;
        @(negedge clk);
        start = 1'b0;
        bin   = 16'd1234;
        lat   = 1;
        repeat (2) begin @(negedge clk); lat++; end
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        en    = 1'b0;
        repeat (5) begin @(negedge clk); lat++; end
        en = 1'b1;
        while (!b5.done_o && lat < 100) begin @(negedge clk); lat++; end
        chk("stall_done", b5.done_o, 1);
        chk("stall_latency", lat - 1, 22);
`ifndef SIGNED_MODE_EN
        chk("stall_bcd", b5.bcd_o, 20'h65233);
`endif
        count_done(30, nd);
        chk("single_done", nd, 0);

        // Reset partway through the shift phase.
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd65233;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", b5.busy_o, 0);
        chk("midrst_bcd",  b5.bcd_o, 0);
        chk("midrst_done", b5.done_o, 0);
        @(negedge clk);
        rst = 1'b0;
        count_done(25, nd);
        chk("midrst_nodone", nd, 0);
        convert(16'd65535, lat);
`ifndef SIGNED_MODE_EN
        chk("d65535_bcd", b5.bcd_o, 20'h65535);
`else
        chk("m1_bcd",  b5.bcd_o, 20'h00001);
        chk("m1_sign", b5.sign_o, 1);
        convert(16'h8000, lat);
        chk("min_bcd",  b5.bcd_o, 20'h32768);
        chk("min_sign", b5.sign_o, 1);
        chk("min_ovf4", b4.overflow_o, 1);
        convert(16'h7FFF, lat);
        chk("max_bcd",  b5.bcd_o, 20'h32767);
        chk("max_sign", b5.sign_o, 0);
`endif

        // Back-to-back requests with start held high.
        @(negedge clk);
        start = 1'b1;
        repeat (60) begin
            bin = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0;

        // Randomized traffic: en gaps, start pulses, edge values, occasional reset.
        nd_rand = 0;
        repeat (3000) begin
            @(negedge clk);
            if (b5.done_o) nd_rand++;
            en    = ($urandom_range(0, 7) != 0);
            start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0: rv = 16'd0;
                1: rv = 16'hFFFF;
                2: rv = 16'h8000;
                3: rv = 16'd9999;
                4: rv = 16'd10000;
                default: rv = 16'($urandom);
            endcase
            bin = rv;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 499) == 0) rst = 1'b1;
        end
        chk("rand_activity", (nd_rand > 20) ? 1 : 0, 1);

        rst   = 1'b0;
        start = 1'b0;
        en    = 1'b1;
        repeat (25) @(negedge clk);
        #3 chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
